// File: rtl/mdu_iterative_unit_if.sv
// Handshake/data bundle between the ID/EX pipeline slot and the multiply/divide unit.
// The pipeline side drives the master modport; the unit uses the slave modport.
interface mdu_iterative_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [4:0]      alu_op;
  logic [XLEN-1:0] data1;
  logic [XLEN-1:0] data2;
  logic            flush;
  logic [XLEN-1:0] result;
  logic            done;
  logic            busy;
  logic            stall;

  modport master (
    output start, alu_op, data1, data2, flush,
    input  result, done, busy, stall
  );

  modport slave (
    input  start, alu_op, data1, data2, flush,
    output result, done, busy, stall
  );
endinterface

// File: rtl/mdu_iterative_unit.sv
// RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Define MDU_FAST_MUL_EN to replace the iterative multiply with a single-cycle 33x33 multiplier.
module mdu_iterative_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic                clk,
  input logic                rst_n,
  mdu_iterative_unit_if.slave bus
);

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_REM    = 3'b110;

  typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

  state_e              r_state, w_state_d;
  logic [2:0]          r_op;
  logic                r_neg_a, r_neg_b;
  logic [XLEN-1:0]     r_a, r_b, r_result;
  logic [2*XLEN-1:0]   r_acc;
  logic [CNT_W-1:0]    r_cnt;

  logic [2:0]          w_f3;
  logic                w_go, w_is_div, w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
  logic                w_special, w_last, w_neg_q, w_unused_op;
  logic [XLEN-1:0]     w_abs_a, w_abs_b, w_special_res, w_fix_res;
  logic [XLEN:0]       w_mul_sum;
  logic [XLEN+1:0]     w_div_diff;
  logic [2*XLEN-1:0]   w_mul_next, w_div_next, w_prod;

  assign w_f3        = bus.alu_op[2:0];
  assign w_unused_op = bus.alu_op[4];
  assign w_go        = bus.start & bus.alu_op[3] & ~bus.flush;
  assign w_is_div    = w_f3[2];
  assign w_sgn_a     = (w_f3 == F_MULH) | (w_f3 == F_MULHSU) | (w_f3 == F_DIV) | (w_f3 == F_REM);
  assign w_sgn_b     = (w_f3 == F_MULH) | (w_f3 == F_DIV) | (w_f3 == F_REM);
  assign w_neg_a     = w_sgn_a & bus.data1[XLEN-1];
  assign w_neg_b     = w_sgn_b & bus.data2[XLEN-1];
  assign w_abs_a     = w_neg_a ? -bus.data1 : bus.data1;
  assign w_abs_b     = w_neg_b ? -bus.data2 : bus.data2;
  assign w_last      = (r_cnt == CNT_W'(XLEN - 1));

  // Divide-by-zero and signed overflow bypass the iteration entirely.
  always_comb begin
    w_special     = 1'b0;
    w_special_res = '0;
    if (w_is_div && bus.data2 == '0) begin
      w_special     = 1'b1;
      w_special_res = w_f3[1] ? bus.data1 : {XLEN{1'b1}};
    end else if (w_is_div && !w_f3[0] && bus.data1 == {1'b1, {(XLEN-1){1'b0}}}
                 && bus.data2 == {XLEN{1'b1}}) begin
      w_special     = 1'b1;
      w_special_res = w_f3[1] ? '0 : bus.data1;
    end
  end

  // Multiply: low half of r_acc holds the remaining multiplier bits.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
  // Divide: 33-bit partial remainder so divisors above 2^31 do not lose the shifted-out bit.
  assign w_div_diff = {1'b0, r_acc[2*XLEN-1:XLEN-1]} - {2'b00, r_b};
  assign w_div_next = w_div_diff[XLEN+1] ? {r_acc[2*XLEN-2:0], 1'b0}
                                         : {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

  assign w_neg_q = r_neg_a ^ r_neg_b;
  assign w_prod  = w_neg_q ? -r_acc : r_acc;

  always_comb begin
    w_fix_res = '0;
    if (!r_op[2]) begin
      w_fix_res = (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    end else if (!r_op[1]) begin
      w_fix_res = w_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    end else begin
      w_fix_res = r_neg_a ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    end
  end

`ifdef MDU_FAST_MUL_EN
  logic [XLEN:0]            w_fa, w_fb;
  logic signed [2*XLEN+1:0] w_fa_ext, w_fb_ext, w_fprod;
  logic [XLEN-1:0]          w_fast_res;

  // Rebuild the signed operands from magnitude and sign flag.
  assign w_fa       = r_neg_a ? -{1'b0, r_a} : {1'b0, r_a};
  assign w_fb       = r_neg_b ? -{1'b0, r_b} : {1'b0, r_b};
  assign w_fa_ext   = {{(XLEN+1){w_fa[XLEN]}}, w_fa};
  assign w_fb_ext   = {{(XLEN+1){w_fb[XLEN]}}, w_fb};
  assign w_fprod    = w_fa_ext * w_fb_ext;
  assign w_fast_res = (r_op[1:0] == 2'b00) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
`endif

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: if (w_go) w_state_d = w_special ? StDone : (w_is_div ? StDiv : StMul);
`ifdef MDU_FAST_MUL_EN
      StMul:  w_state_d = StDone;
`else
      StMul:  if (w_last) w_state_d = StFix;
`endif
      StDiv:  if (w_last) w_state_d = StFix;
      StFix:  w_state_d = StDone;
      StDone: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    if (bus.flush) w_state_d = StIdle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      unique case (r_state)
        StIdle: if (w_go) begin
          r_op    <= w_f3;
          r_neg_a <= w_neg_a;
          r_neg_b <= w_neg_b;
          r_a     <= w_abs_a;
          r_b     <= w_abs_b;
          r_acc   <= {{XLEN{1'b0}}, w_abs_a};
          r_cnt   <= '0;
          if (w_special) r_result <= w_special_res;
        end
`ifdef MDU_FAST_MUL_EN
        StMul: if (!bus.flush) r_result <= w_fast_res;
`else
        StMul: begin
          r_acc <= w_mul_next;
          if (!w_last) r_cnt <= r_cnt + CNT_W'(1);
        end
`endif
        StDiv: begin
          r_acc <= w_div_next;
          if (!w_last) r_cnt <= r_cnt + CNT_W'(1);
        end
        StFix: if (!bus.flush) r_result <= w_fix_res;
        default: ;
      endcase
    end
  end

  assign bus.result = r_result;
  assign bus.done   = (r_state == StDone);
  assign bus.busy   = (r_state != StIdle);
  assign bus.stall  = (w_go & (r_state == StIdle)) | (bus.busy & ~bus.done);

endmodule

// File: tb/tb_mdu_iterative_unit.sv
// Self-checking bench for mdu_iterative_unit: directed corner cases, flush/reset, random ops
// against a plain-arithmetic RV32M reference model.
module tb_mdu_iterative_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mdu_iterative_unit_if bus ();

  mdu_iterative_unit #(
    .XLEN  (32),
    .CNT_W (6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef MDU_FAST_MUL_EN
  localparam int MulLat = 2;
`else
  localparam int MulLat = 34;
`endif

  int          passed = 0;
  int          total  = 0;
  logic [31:0] last_exp = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ua, ub, r;
    logic   ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'h0, a});
    ub  = longint'({32'h0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin r = sa * sb; return r[31:0];  end
      3'd1: begin r = sa * sb; return r[63:32]; end
      3'd2: begin r = sa * ub; return r[63:32]; end
      3'd3: begin r = ua * ub; return r[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return a;
        r = sa / sb; return r[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        r = ua / ub; return r[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return 32'h0;
        r = sa % sb; return r[31:0];
      end
      default: begin
        if (b == 0) return a;
        r = ua % ub; return r[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return MulLat;
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Called just after a rising edge; returns just after a rising edge.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    int   n;
    logic stall_bad;
    bus.start  = 1'b1;
    bus.alu_op = {2'b01, f3};
    bus.data1  = a;
    bus.data2  = b;
    #1;
    check({tag, " stall@start"}, 32'(bus.stall), 32'd1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.data1 = $urandom;
    bus.data2 = $urandom;
    n         = 1;
    stall_bad = 1'b0;
    while (bus.done !== 1'b1 && n < 100) begin
      if (bus.stall !== 1'b1) stall_bad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(ref_lat(f3, a, b)));
    check({tag, " result"}, bus.result, exp);
    check({tag, " stall before done"}, 32'(stall_bad), 32'd0);
    check({tag, " stall@done"}, 32'(bus.stall), 32'd0);
    @(posedge clk); #1;
    check({tag, " done/busy after"}, {30'd0, bus.done, bus.busy}, 32'd0);
    last_exp = exp;
  endtask

  initial begin
    int          dones;
    logic [2:0]  f3;
    logic [31:0] a, b;

    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.alu_op = '0;
    bus.data1  = '0;
    bus.data2  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset result", bus.result, 32'h0);
    check("reset done/busy/stall", {29'd0, bus.done, bus.busy, bus.stall}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("MUL 7*-3",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
    do_op("MULH min*min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    do_op("MULHU",       3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_op("MULHSU",      3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("DIV -20/3",   3'd4, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA);
    do_op("REM -20/3",   3'd6, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE);
    do_op("DIVU 100/7",  3'd5, 32'd100,        32'd7,         32'd14);
    do_op("REMU 100/7",  3'd7, 32'd100,        32'd7,         32'd2);
    do_op("DIVU 5/0",    3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF);
    do_op("REM 5/0",     3'd6, 32'd5,          32'd0,         32'd5);
    do_op("DIV ovf",     3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
    do_op("REM ovf",     3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0);

    // Flush partway through a divide.
    bus.start  = 1'b1;
    bus.alu_op = 5'b01100;
    bus.data1  = 32'd1000;
    bus.data2  = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush busy", 32'(bus.busy), 32'd0);
    check("flush result kept", bus.result, last_exp);
    dones = 0;
    repeat (40) begin
      if (bus.done === 1'b1) dones++;
      @(posedge clk); #1;
    end
    check("flush no done", 32'(dones), 32'd0);

    // Start and flush on the same edge.
    bus.start  = 1'b1;
    bus.flush  = 1'b1;
    bus.alu_op = 5'b01101;
    bus.data1  = 32'd77;
    bus.data2  = 32'd0;
    #1;
    check("start+flush stall", 32'(bus.stall), 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("start+flush busy/done", {30'd0, bus.busy, bus.done}, 32'd0);
    check("start+flush result", bus.result, last_exp);

    // Reset mid-divide.
    bus.start  = 1'b1;
    bus.alu_op = 5'b01100;
    bus.data1  = 32'd12345;
    bus.data2  = 32'd17;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid reset flags", {29'd0, bus.busy, bus.done, bus.stall}, 32'd0);
    check("mid reset result", bus.result, 32'h0);
    @(posedge clk); #1;
    rst_n    = 1'b1;
    last_exp = '0;
    @(posedge clk); #1;
    do_op("DIVU 9/2 post-reset", 3'd5, 32'd9, 32'd2, 32'd4);

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 100));
        default: ;
      endcase
      do_op($sformatf("rand%0d f3=%0d", i, f3), f3, a, b, ref_mdu(f3, a, b));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
